// File: rtl/rand_sum_gen.sv
// rtl/rand_sum_gen.sv - LFSR random-sum generator with sequential mean/remainder divider
module rand_sum_gen #(
    parameter int          WIDTH     = 8,
    parameter int          NUM_TERMS = 3,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         SUM_W     = WIDTH + $clog2(NUM_TERMS)
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sample,
    output logic [SUM_W-1:0] sum,
    output logic [SUM_W-1:0] mean,
    output logic [SUM_W-1:0] rem
);

    localparam logic [15:0]      SEED_EFF  = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [SUM_W-1:0] DIVISOR   = SUM_W'(NUM_TERMS);
    localparam logic [7:0]       LAST_TERM = 8'(NUM_TERMS - 1);
    localparam logic [4:0]       LAST_DIV  = 5'(SUM_W - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DIV, DONE} state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_step;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_next;
    logic [SUM_W-1:0] quo;
    logic [SUM_W-1:0] rmd;
    logic [SUM_W:0]   rmd_shift;
    logic [SUM_W-1:0] rmd_sub;
    logic             quo_bit;
    logic [7:0]       term_cnt;
    logic [4:0]       div_cnt;

    // A zero LFSR state is a lock-up; the step recovers by reloading the seed.
    always_comb begin
        lfsr_step = 16'h0;
        if (lfsr == 16'h0) begin
            lfsr_step = SEED_EFF;
        end else begin
            lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
        acc_next  = acc + SUM_W'(lfsr_step[WIDTH-1:0]);
        rmd_shift = {rmd, quo[SUM_W-1]};
        quo_bit   = (rmd_shift >= {1'b0, DIVISOR});
        rmd_sub   = rmd_shift[SUM_W-1:0] - DIVISOR;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lfsr     <= SEED_EFF;
            busy     <= 1'b0;
            done     <= 1'b0;
            sample   <= '0;
            sum      <= '0;
            mean     <= '0;
            rem      <= '0;
            acc      <= '0;
            quo      <= '0;
            rmd      <= '0;
            term_cnt <= '0;
            div_cnt  <= '0;
        end else begin
            done <= 1'b0;
            busy <= (state == DRAW) || (state == DIV);
            if (state != DRAW && lfsr == 16'h0) begin
                lfsr <= SEED_EFF;
            end
            case (state)
                IDLE: begin
                    acc      <= '0;
                    term_cnt <= '0;
                    if (start) begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    lfsr     <= lfsr_step;
                    sample   <= lfsr_step[WIDTH-1:0];
                    acc      <= acc_next;
                    term_cnt <= term_cnt + 8'd1;
                    if (term_cnt == LAST_TERM) begin
                        quo     <= acc_next;
                        rmd     <= '0;
                        div_cnt <= '0;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    // Restoring step: the quotient register doubles as the dividend shifter.
                    quo     <= SUM_W'({quo, quo_bit});
                    rmd     <= quo_bit ? rmd_sub : rmd_shift[SUM_W-1:0];
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == LAST_DIV) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    sum   <= acc;
                    mean  <= quo;
                    rem   <= rmd;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_sum_gen.sv
// tb/tb_rand_sum_gen.sv - directed table-driven bench for rand_sum_gen
module tb_rand_sum_gen;

    logic       clk = 1'b0;
    logic       rst_n, start, start1;
    logic       busy, done, busy1, done1;
    logic [7:0] sample, sample1;
    logic [9:0] sum, mean, rem;
    logic [7:0] sum1, mean1, rem1;

    always #5 clk = ~clk;

    rand_sum_gen u0 (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .sample(sample), .sum(sum), .mean(mean), .rem(rem)
    );

    rand_sum_gen #(.NUM_TERMS(1)) u1 (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .sample(sample1), .sum(sum1), .mean(mean1), .rem(rem1)
    );

    typedef struct {
        bit reset_before;
        bit pokes;
        int s0, s1, s2, sum, mean, rem;
    } vec_t;

    vec_t tbl[3];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat, bcnt, dcnt;
    int   smp[3];
    int   dcyc[4], dsum[4], dmean[4], drem[4];
    int   nd;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_default(input bit pokes);
        lat  = -1;
        bcnt = 0;
        dcnt = 0;
        smp  = '{-1, -1, -1};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (busy) begin
                bcnt++;
                if (bcnt <= 3) smp[bcnt-1] = int'(sample);
            end
            if (done) begin
                dcnt++;
                if (lat < 0) lat = c;
            end
            if (pokes) start = (c <= 13) && (c % 2 == 1);
        end
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 0, 112, 56, 156, 324, 108, 0};
        tbl[1] = '{0, 0, 78, 39, 19, 136, 45, 1};
        tbl[2] = '{0, 1, 112, 56, 156, 324, 108, 0};

        rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sample", sample, 0);
        chk("reset_sum", sum, 0);
        chk("reset_mean", mean, 0);
        chk("reset_rem", rem, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-term instance: divide by one still takes SUM_W cycles
        lat = -1; dcnt = 0; smp[0] = -1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (busy1 && smp[0] < 0) smp[0] = int'(sample1);
            if (done1) begin
                dcnt++;
                if (lat < 0) lat = c;
            end
        end
        chk("n1_sample", smp[0], 112);
        chk("n1_sum", sum1, 112);
        chk("n1_mean", mean1, 112);
        chk("n1_rem", rem1, 0);
        chk("n1_latency", lat, 10);
        chk("n1_done_count", dcnt, 1);

        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                // Abort a run with reset during the second draw cycle
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                nd = 0;
                for (int c = 1; c <= 2; c++) begin
                    @(posedge clk); #1;
                    if (done) nd++;
                end
                rst_n = 1'b0;
                #1;
                chk("abort_no_done_before", nd, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_sample", sample, 0);
                chk("abort_sum", sum, 0);
                chk("abort_mean", mean, 0);
                chk("abort_rem", rem, 0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            if (tbl[i].reset_before) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            run_default(tbl[i].pokes);
            chk($sformatf("v%0d_sample0", i), smp[0], tbl[i].s0);
            chk($sformatf("v%0d_sample1", i), smp[1], tbl[i].s1);
            chk($sformatf("v%0d_sample2", i), smp[2], tbl[i].s2);
            chk($sformatf("v%0d_sum", i), sum, tbl[i].sum);
            chk($sformatf("v%0d_mean", i), mean, tbl[i].mean);
            chk($sformatf("v%0d_rem", i), rem, tbl[i].rem);
            chk($sformatf("v%0d_latency", i), lat, 14);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, 13);
            chk($sformatf("v%0d_done_count", i), dcnt, 1);
        end

        // Held start: back-to-back runs on a 15-cycle spacing
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        start = 1'b1;
        for (int c = 0; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (nd < 4) begin
                    dcyc[nd]  = c;
                    dsum[nd]  = int'(sum);
                    dmean[nd] = int'(mean);
                    drem[nd]  = int'(rem);
                end
                nd++;
            end
            if (c == 39) start = 1'b0;
        end
        start = 1'b0;
        chk("held_done_count", nd, 3);
        if (nd >= 3) begin
            chk("held_done0_cycle", dcyc[0], 14);
            chk("held_done1_cycle", dcyc[1], 29);
            chk("held_done2_cycle", dcyc[2], 44);
            chk("held_sum0", dsum[0], 324);
            chk("held_mean0", dmean[0], 108);
            chk("held_rem0", drem[0], 0);
            chk("held_sum1", dsum[1], 136);
            chk("held_mean1", dmean[1], 45);
            chk("held_rem1", drem[1], 1);
            chk("held_sum2", dsum[2], 431);
            chk("held_mean2", dmean[2], 143);
            chk("held_rem2", drem[2], 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rand_sum_gen.md
Name: rand_sum_gen

Overview:
- Parametrised successor to the fixed three-term random-sum datapath. On each start request it draws NUM_TERMS pseudo-random samples from an internal 16-bit Galois LFSR and accumulates their sum.
- It then computes the integer mean (sum / NUM_TERMS) and remainder with a sequential restoring divider.
- Sits between the KEY debounce logic and the LED/HEX display drivers in the top level.

Parameters:
- WIDTH, 8, sample width in bits (1..16); a sample is the low WIDTH bits of the LFSR state.
- NUM_TERMS, 3, number of samples summed per run (1..255).
- SEED, 16'hACE1, LFSR reset and reload value; a value of 0 is replaced by 16'hACE1.
- SUM_W, WIDTH+$clog2(NUM_TERMS), derived local width of the sum, mean and remainder; not overridable.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset, driven from KEY[0] at top level.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high in DRAW and DIV.
- done  out  1  single-cycle pulse when results update.
- sample  out  WIDTH  last drawn sample.
- sum  out  SUM_W  sum of the NUM_TERMS samples of the last completed run.
- mean  out  SUM_W  floor(sum / NUM_TERMS).
- rem  out  SUM_W  sum mod NUM_TERMS.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE and the LFSR loads SEED.
  - busy, done, sample, sum, mean and rem all clear to 0.
  - Reset asserted mid-run aborts the run with no done pulse.
- LFSR step: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - It advances only in DRAW, once per cycle, so runs are deterministic from reset.
  - If the state is ever 0, it reloads SEED on the next cycle.
- FSM states: IDLE, DRAW, DIV, DONE.
- IDLE:
  - start=1 goes to DRAW.
  - The accumulator and term counter clear; outputs hold their previous results.
- DRAW (exactly NUM_TERMS cycles):
  - Each cycle the LFSR steps; the new state's low WIDTH bits are added to the accumulator and registered on sample.
  - The accumulator is SUM_W bits wide and cannot overflow.
  - After the last term, go to DIV.
- DIV (exactly SUM_W cycles):
  - Restoring division of the accumulator by NUM_TERMS, MSB first, one quotient bit per cycle.
  - The remainder register is SUM_W bits; the divisor is a constant zero-extended to SUM_W.
  - Then go to DONE.
- DONE (1 cycle):
  - sum, mean and rem update; done=1 and busy=0.
  - Next state is IDLE; start is ignored in DONE.
- Latency: start sampled high at edge k gives done high in the cycle after edge k+NUM_TERMS+SUM_W+1.
  - Defaults (3 terms, SUM_W=10): 14 cycles.
  - Minimum start-to-start spacing is NUM_TERMS+SUM_W+2 cycles.
- start while busy or in DONE is ignored and not queued. A start held high re-triggers from IDLE.
- sum, mean and rem change only in DONE and are held stable otherwise. sample changes only in DRAW.
- NUM_TERMS=1: mean=sum and rem=0, and the divider still runs SUM_W cycles.

Test Plan:
- Reset, then a start pulse with defaults:
  - samples 112, 56, 156; sum=324, mean=108, rem=0.
  - busy high for 13 cycles; done exactly 14 cycles after start.
- Second start after done:
  - samples 78, 39, 19; sum=136, mean=45, rem=1 (LFSR continues from 16'h389C).
- Start pulsed repeatedly during busy and during DONE:
  - no extra run; results identical to the first scenario; exactly one done pulse.
- rst_n low at DRAW cycle 2, then release and start:
  - no done before the reset; busy and outputs read 0 during reset.
  - the new run reproduces 112/56/156 and sum=324.
- NUM_TERMS=1, WIDTH=8:
  - sample=112, sum=112, mean=112, rem=0; done 10 cycles after start.
- Start held high for 40 cycles:
  - back-to-back runs every 15 cycles; no run starts in DONE; results match scenarios 1 and 2 in order.
